bcd_counter_display: RTL and testbench



---
 rtl/bcd_counter_display_pkg.sv | 43 ++++
 rtl/bcd_counter_display_digit.sv | 38 +++
 rtl/bcd_counter_display.sv | 135 +++++++++++++
 tb/tb_bcd_counter_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_display_pkg.sv
// ----------------------------------------------------------------------------
// bcd_counter_display_pkg : BCD limits, 7-segment patterns, decode fn  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package bcd_counter_display_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Segment order is {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_counter_display_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit : one BCD decade with ripple carry (up) / borrow (down)  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_digit
  import bcd_counter_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       dir,
  input  logic       carry_in,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       carry_out
);

  // carry_in/carry_out act as borrow_in/borrow_out when dir=0
  assign carry_out = carry_in & (dir ? (digit == BCD_MAX) : (digit == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= (load_digit > BCD_MAX) ? BCD_MAX : load_digit;
    end else if (step && carry_in) begin
      if (dir)
        digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
      else
        digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_counter_display.sv
// ----------------------------------------------------------------------------
// bcd_counter_display : N-digit BCD up/down counter, muxed 7-seg driver  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int PW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc;
  logic                  step;
  logic [NUM_DIGITS:0]   carry;
  logic [3:0]            digits [NUM_DIGITS];
  logic [SW-1:0]         scan_cnt;
  logic                  scan_wrap;
  logic [IW-1:0]         scan_idx;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [6:0]            seg_next;

  // ---------------- prescaler / step ----------------
  assign step = en & (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end
  end

  // A load suppresses the coincident step, so neither pulse is reported
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step & ~load;
      wrap <= step & ~load & carry[NUM_DIGITS];
    end
  end

  // ---------------- digit chain ----------------
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (step),
      .dir        (dir),
      .carry_in   (carry[i]),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .digit      (digits[i]),
      .carry_out  (carry[i+1])
    );
    assign count[4*i +: 4] = digits[i];
  end

  // ---------------- leading-zero detect and digit mux ----------------
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz         = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (digits[i] == 4'd0);
      lz[i]      = upper_zero;
    end
  end

  always_comb begin
    cur_digit = digits[0];
    cur_blank = 1'b0;
    sel_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        cur_digit = digits[i];
        cur_blank = lz[i];
      end
      sel_next[i] = (scan_idx == IW'(i));
    end
    seg_next = ((BLANK_LZ != 0) && cur_blank) ? SEG_BLANK : seg_decode(cur_digit);
  end

  // ---------------- scan timing and output registers ----------------
  assign scan_wrap = (scan_cnt == SCAN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      digit_sel <= NUM_DIGITS'(1);
      seg       <= SEG_0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap)
        scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
      digit_sel <= sel_next;
      seg       <= seg_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_display.sv
// ----------------------------------------------------------------------------
// tb_bcd_counter_display : directed self-checking bench  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_counter_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tick;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] digit_sel;

  int total = 0;
  int bad   = 0;

  bcd_counter_display #(
    .NUM_DIGITS (2),
    .TICK_DIV   (4),
    .SCAN_DIV   (2),
    .BLANK_LZ   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .tick      (tick),
    .wrap      (wrap),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; leaves prescaler cleared and count = v
  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Returns on the first sample where digit_sel has just switched 01 -> 10
  task automatic sync_sel(output logic ok);
    logic [1:0] prev;
    ok   = 1'b0;
    prev = digit_sel;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (prev == 2'b01 && digit_sel == 2'b10) ok = 1'b1;
      else prev = digit_sel;
    end
  endtask

  initial begin
    logic ok;
    logic tick_seen;

    rst_n = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b0; load_val = 8'h00;
    @(negedge clk);
    check("rst_count", count, 8'h00);
    check("rst_seg",   seg,   7'h3F);
    check("rst_sel",   digit_sel, 2'b01);
    check("rst_tick",  tick,  1'b0);
    check("rst_wrap",  wrap,  1'b0);

    rst_n = 1'b1;
    wait_clks(3);
    check("pre_first_tick_count", count, 8'h00);
    check("pre_first_tick",       tick,  1'b0);
    wait_clks(1);
    check("first_tick_count", count, 8'h01);
    check("first_tick",       tick,  1'b1);
    wait_clks(1);
    check("tick_one_cycle", tick, 1'b0);

    // Up-count across the all-9s boundary
    do_load(8'h98);
    check("load_98", count, 8'h98);
    wait_clks(4);
    check("up_99",      count, 8'h99);
    check("up_99_wrap", wrap,  1'b0);
    wait_clks(4);
    check("up_wrap_count", count, 8'h00);
    check("up_wrap_flag",  wrap,  1'b1);
    wait_clks(1);
    check("up_wrap_clear", wrap, 1'b0);
    wait_clks(3);
    check("up_01",      count, 8'h01);
    check("up_01_wrap", wrap,  1'b0);

    // Down-count across the all-0s boundary and a decade borrow
    dir = 1'b0;
    do_load(8'h00);
    wait_clks(4);
    check("down_99",      count, 8'h99);
    check("down_99_wrap", wrap,  1'b1);
    wait_clks(1);
    check("down_wrap_clear", wrap, 1'b0);
    wait_clks(3);
    check("down_98", count, 8'h98);
    do_load(8'h19);
    wait_clks(36);
    check("down_10", count, 8'h10);
    wait_clks(4);
    check("down_09",      count, 8'h09);
    check("down_09_wrap", wrap,  1'b0);

    // Load with en=0, including a saturated non-BCD digit
    en  = 1'b0;
    dir = 1'b1;
    do_load(8'hA3);
    check("load_sat", count, 8'h93);
    tick_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tick_seen = tick_seen | tick;
    end
    check("no_tick_en0", tick_seen, 1'b0);
    check("hold_en0",    count,     8'h93);
    en = 1'b1;
    wait_clks(3);
    check("resume_hold", count, 8'h93);
    wait_clks(1);
    check("resume_step", count, 8'h94);

    // Load arriving on the step edge takes priority
    wait_clks(3);
    do_load(8'h42);
    check("load_wins",      count, 8'h42);
    check("load_wins_wrap", wrap,  1'b0);
    wait_clks(3);
    check("after_load_hold", count, 8'h42);
    wait_clks(1);
    check("after_load_step", count, 8'h43);

    // Scan with leading-zero blanking
    en = 1'b0;
    do_load(8'h05);
    wait_clks(2);
    sync_sel(ok);
    check("scan05_sync", ok, 1'b1);
    check("scan05_sel_hi_a", digit_sel, 2'b10);
    check("scan05_seg_hi_a", seg,       7'h00);
    wait_clks(1);
    check("scan05_sel_hi_b", digit_sel, 2'b10);
    check("scan05_seg_hi_b", seg,       7'h00);
    wait_clks(1);
    check("scan05_sel_lo_a", digit_sel, 2'b01);
    check("scan05_seg_lo_a", seg,       7'h6D);
    wait_clks(1);
    check("scan05_sel_lo_b", digit_sel, 2'b01);
    check("scan05_seg_lo_b", seg,       7'h6D);
    wait_clks(1);
    check("scan05_sel_hi_c", digit_sel, 2'b10);

    do_load(8'h50);
    wait_clks(2);
    sync_sel(ok);
    check("scan50_sync",   ok,  1'b1);
    check("scan50_seg_hi", seg, 7'h6D);
    wait_clks(2);
    check("scan50_sel_lo", digit_sel, 2'b01);
    check("scan50_seg_lo", seg,       7'h3F);

    // Asynchronous reset in the middle of counting
    en = 1'b1;
    do_load(8'h37);
    check("pre_reset_count", count, 8'h37);
    sync_sel(ok);
    check("pre_reset_sync", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", count,     8'h00);
    check("async_sel",   digit_sel, 2'b01);
    check("async_seg",   seg,       7'h3F);
    check("async_wrap",  wrap,      1'b0);
    check("async_tick",  tick,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(3);
    check("post_reset_hold", count, 8'h00);
    wait_clks(1);
    check("post_reset_step", count, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
